ws2812_chain_driver: RTL and testbench

WS2812_CHAIN_DRIVER -- requirements
Module: ws2812_chain_driver

---
 rtl/ws2812_chain_driver.sv | 171 +++++++++++++++++
 tb/tb_ws2812_chain_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_chain_driver.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_chain_driver
// Description : Drives CH_NUM parallel WS2812 LED strings from an internal
//               pixel RAM, with global brightness scaling, single-shot or
//               auto-repeat frames and a trailing latch (reset) code.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_chain_driver #(
    parameter int CH_NUM      = 4,
    parameter int LED_NUM     = 4,
    parameter int CLK_HZ      = 100000000,
    parameter int T0H_NS      = 400,
    parameter int T1H_NS      = 800,
    parameter int BIT_NS      = 1250,
    parameter int RST_US      = 80,
    parameter int COLOR_ORDER = 0
) (
    input  logic                                          clk100,
    input  logic                                          reset_n,
    input  logic                                          ram_we,
    input  logic [((CH_NUM  > 1) ? $clog2(CH_NUM)  : 1)-1:0] ram_wrch,
    input  logic [((LED_NUM > 1) ? $clog2(LED_NUM) : 1)-1:0] ram_wraddress,
    input  logic [23:0]                                   ram_data,
    input  logic [7:0]                                    bright,
    input  logic                                          refresh_en,
    input  logic                                          update_request,
    output logic                                          update_done,
    output logic                                          busy,
    output logic [CH_NUM-1:0]                             DOUT,
    output logic                                          RST
);

    localparam int c_LED_W  = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int c_MHZ    = CLK_HZ / 1000000;
    localparam int c_T0H    = c_MHZ * T0H_NS / 1000;
    localparam int c_T1H    = c_MHZ * T1H_NS / 1000;
    localparam int c_BIT    = c_MHZ * BIT_NS / 1000;
    localparam int c_RST    = c_MHZ * RST_US;
    localparam int c_CNT_W  = (c_BIT > 1) ? $clog2(c_BIT) : 1;
    localparam int c_RCNT_W = (c_RST > 1) ? $clog2(c_RST) : 1;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_START      = 2'd1;
    localparam logic [1:0] c_SHIFT      = 2'd2;
    localparam logic [1:0] c_RESET_CODE = 2'd3;

    // Brightness-scale one colour byte: (c*(bright+1))>>8
    function automatic logic [7:0] f_scale(input logic [7:0] col, input logic [7:0] br);
        logic [15:0] v_prod;
        v_prod = 16'(col) * (16'(br) + 16'd1);
        return 8'(v_prod >> 8);
    endfunction

    // Scale and reorder a stored {R,G,B} word into line order
    function automatic logic [23:0] f_format(input logic [23:0] rgb, input logic [7:0] br);
        logic [7:0] v_r, v_g, v_b;
        v_r = f_scale(rgb[23:16], br);
        v_g = f_scale(rgb[15:8], br);
        v_b = f_scale(rgb[7:0], br);
        return (COLOR_ORDER == 0) ? {v_g, v_r, v_b} : {v_r, v_g, v_b};
    endfunction

    logic [23:0]         r_ram  [CH_NUM][LED_NUM];
    logic [23:0]         r_word [CH_NUM];
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [4:0]          r_bit_idx;
    logic [c_LED_W-1:0]  r_led_idx;
    logic [c_RCNT_W-1:0] r_rst_cnt;
    logic                r_pending;
    logic                w_bit_end;
    logic                w_word_end;
    logic                w_last_led;
    logic                w_rst_end;
    logic [c_LED_W-1:0]  w_next_led;

    assign w_bit_end  = (r_cnt == c_CNT_W'(c_BIT - 1));
    assign w_word_end = w_bit_end && (r_bit_idx == 5'd23);
    assign w_last_led = (r_led_idx == c_LED_W'(LED_NUM - 1));
    assign w_rst_end  = (r_rst_cnt == c_RCNT_W'(c_RST - 1));
    assign w_next_led = w_last_led ? '0 : r_led_idx + c_LED_W'(1);

    // Pixel RAM: writable in every state, out-of-range targets dropped; not reset
    always_ff @(posedge clk100) begin
        if (ram_we && (32'(ram_wrch) < 32'(CH_NUM)) && (32'(ram_wraddress) < 32'(LED_NUM)))
            r_ram[ram_wrch][ram_wraddress] <= ram_data;
    end

    // State register
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) r_state <= c_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != c_IDLE);
        RST         = (r_state == c_RESET_CODE);
        update_done = (r_state == c_RESET_CODE) && w_rst_end;
        case (r_state)
            c_IDLE:       if (update_request || refresh_en) w_state_nxt = c_START;
            c_START:      w_state_nxt = c_SHIFT;
            c_SHIFT:      if (w_word_end && w_last_led) w_state_nxt = c_RESET_CODE;
            c_RESET_CODE: if (w_rst_end)
                              w_state_nxt = (r_pending || update_request || refresh_en) ? c_START : c_IDLE;
            default:      w_state_nxt = c_IDLE;
        endcase
    end

    // Bit/word/LED timing counters and pending-request latch
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_led_idx <= '0;
            r_rst_cnt <= '0;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                c_START: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    r_led_idx <= '0;
                end
                c_SHIFT: begin
                    r_rst_cnt <= '0;
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 5'd23) begin
                            r_bit_idx <= '0;
                            r_led_idx <= w_next_led;
                        end else begin
                            r_bit_idx <= r_bit_idx + 5'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_RESET_CODE: r_rst_cnt <= r_rst_cnt + c_RCNT_W'(1);
                default: ;
            endcase
            if (w_state_nxt == c_START)                 r_pending <= 1'b0;
            else if (r_state != c_IDLE && update_request) r_pending <= 1'b1;
        end
    end

    // Per-channel shift words: LED 0 fetched in START, next LED fetched on the
    // last cycle of the current word so LEDs follow back-to-back
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < CH_NUM; ch++) r_word[ch] <= '0;
        end else if (r_state == c_START) begin
            for (int ch = 0; ch < CH_NUM; ch++) r_word[ch] <= f_format(r_ram[ch][0], bright);
        end else if (r_state == c_SHIFT && w_bit_end) begin
            for (int ch = 0; ch < CH_NUM; ch++) begin
                if (w_word_end) r_word[ch] <= f_format(r_ram[ch][w_next_led], bright);
                else            r_word[ch] <= {r_word[ch][22:0], 1'b0};
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_dout
        assign DOUT[g] = (r_state == c_SHIFT) &&
                         (r_cnt < (r_word[g][23] ? c_CNT_W'(c_T1H) : c_CNT_W'(c_T0H)));
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_chain_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_chain_driver
// Description : Self-checking bench for ws2812_chain_driver. Expected line
//               levels are computed per cycle from the pixel model, brightness
//               and the WS2812 bit timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_chain_driver;

    localparam int CH   = 3;
    localparam int LEDS = 3;
    // 20 MHz clock: T0H=8, T1H=16, BIT=25, reset code 10us = 200 cycles
    localparam int T0H  = 8;
    localparam int T1H  = 16;
    localparam int BITC = 25;
    localparam int RSTC = 200;
    localparam int FRAME_CYC = LEDS * 24 * BITC;

    logic          clk100 = 1'b0;
    logic          reset_n = 1'b0;
    logic          ram_we = 1'b0;
    logic [1:0]    ram_wrch = '0;
    logic [1:0]    ram_wraddress = '0;
    logic [23:0]   ram_data = '0;
    logic [7:0]    bright = 8'd255;
    logic          refresh_en = 1'b0;
    logic          update_request = 1'b0;
    wire           update_done;
    wire           busy;
    wire [CH-1:0]  DOUT;
    wire           RST;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [23:0] model_ram [CH][LEDS];
    logic [23:0] exp_word  [CH][LEDS];

    ws2812_chain_driver #(
        .CH_NUM(CH), .LED_NUM(LEDS), .CLK_HZ(20000000),
        .T0H_NS(400), .T1H_NS(800), .BIT_NS(1250), .RST_US(10), .COLOR_ORDER(0)
    ) dut (
        .clk100(clk100), .reset_n(reset_n), .ram_we(ram_we), .ram_wrch(ram_wrch),
        .ram_wraddress(ram_wraddress), .ram_data(ram_data), .bright(bright),
        .refresh_en(refresh_en), .update_request(update_request),
        .update_done(update_done), .busy(busy), .DOUT(DOUT), .RST(RST)
    );

    always #5 clk100 = ~clk100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        int v;
        v = (int'(c) * (int'(b) + 1)) / 256;
        return 8'(v);
    endfunction

    // Line order G,R,B from stored {R,G,B}
    function automatic logic [23:0] fmt(input logic [23:0] rgb, input logic [7:0] b);
        return {scale(rgb[15:8], b), scale(rgb[23:16], b), scale(rgb[7:0], b)};
    endfunction

    function automatic logic exp_level(input int ch, input int i);
        int slot, ph, led, bi;
        logic [23:0] w;
        slot = i / BITC;
        ph   = i % BITC;
        led  = slot / 24;
        bi   = slot % 24;
        w    = exp_word[ch][led];
        return (ph < (w[23 - bi] ? T1H : T0H));
    endfunction

    task automatic snapshot();
        for (int c = 0; c < CH; c++)
            for (int l = 0; l < LEDS; l++) exp_word[c][l] = fmt(model_ram[c][l], bright);
    endtask

    task automatic ram_write(input int ch, input int led, input logic [23:0] d);
        ram_we = 1'b1; ram_wrch = 2'(ch); ram_wraddress = 2'(led); ram_data = d;
        @(negedge clk100);
        ram_we = 1'b0;
        if (ch < CH && led < LEDS) model_ram[ch][led] = d;
    endtask

    // Called one negedge before START; returns on the negedge of the final reset-code cycle
    task automatic run_frame(input string tag, input bit keep_refresh, input int wr_at,
                             input int wr_ch, input int wr_led, input logic [23:0] wr_val,
                             input bit pulse_reqs);
        int mism [CH];
        int ctl_mism, rst_mism, done_cnt;
        snapshot();
        ctl_mism = 0; rst_mism = 0; done_cnt = 0;
        for (int c = 0; c < CH; c++) mism[c] = 0;
        @(negedge clk100);
        check($sformatf("%s_start", tag), 32'({busy, RST, update_done, DOUT}), 32'(6'b100000));
        update_request = 1'b0;
        if (!keep_refresh) refresh_en = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk100);
            for (int c = 0; c < CH; c++) if (DOUT[c] !== exp_level(c, i)) mism[c]++;
            if (RST !== 1'b0 || update_done !== 1'b0 || busy !== 1'b1) ctl_mism++;
            if (i == wr_at) begin
                ram_we = 1'b1; ram_wrch = 2'(wr_ch); ram_wraddress = 2'(wr_led); ram_data = wr_val;
                model_ram[wr_ch][wr_led] = wr_val;
                // LED n is latched at the edge starting cycle n*24*BITC
                if (i + 1 < wr_led * 24 * BITC) exp_word[wr_ch][wr_led] = fmt(wr_val, bright);
            end
            if (i == wr_at + 1) ram_we = 1'b0;
            if (pulse_reqs) update_request = (i == 100 || i == 300 || i == 500);
        end
        update_request = 1'b0;
        for (int c = 0; c < CH; c++)
            check($sformatf("%s_dout_ch%0d_mismatch_cycles", tag, c), 32'(mism[c]), 32'd0);
        check($sformatf("%s_ctrl_in_shift", tag), 32'(ctl_mism), 32'd0);
        for (int j = 0; j < RSTC; j++) begin
            @(negedge clk100);
            if (RST !== 1'b1 || DOUT !== '0 || busy !== 1'b1) rst_mism++;
            if (update_done !== (j == RSTC - 1)) rst_mism++;
            if (update_done === 1'b1) done_cnt++;
        end
        check($sformatf("%s_reset_code", tag), 32'(rst_mism), 32'd0);
        check($sformatf("%s_done_pulses", tag), 32'(done_cnt), 32'd1);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        int act;
        act = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk100);
            if (busy !== 1'b0 || update_done !== 1'b0 || RST !== 1'b0 || DOUT !== '0) act++;
        end
        check(tag, 32'(act), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk100);
        check("reset_outputs", 32'({busy, RST, update_done, DOUT}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk100);
        check("after_reset_idle", 32'({busy, RST, update_done, DOUT}), 32'd0);

        // Random fill, plus out-of-range writes that must be dropped
        for (int c = 0; c < CH; c++)
            for (int l = 0; l < LEDS; l++) ram_write(c, l, 24'($urandom));
        ram_write(3, 0, 24'hFFFFFF);
        ram_write(0, 3, 24'hFFFFFF);

        // Red on CH0, full brightness
        for (int l = 0; l < LEDS; l++) ram_write(0, l, 24'hFF0000);
        update_request = 1'b1;
        run_frame("red_ch0", 0, -1, 0, 0, 0, 0);
        expect_idle("idle_after_single", 20);

        // Channel alignment with differing bit values
        ram_write(0, 0, 24'h000001);
        ram_write(1, 0, 24'h800000);
        update_request = 1'b1;
        run_frame("align", 0, -1, 0, 0, 0, 0);

        // bright=127 on white -> 0x7F bytes
        bright = 8'd127;
        for (int c = 0; c < CH; c++)
            for (int l = 0; l < LEDS; l++) ram_write(c, l, 24'hFFFFFF);
        update_request = 1'b1;
        run_frame("bright127", 0, -1, 0, 0, 0, 0);

        // bright=0 then random brightness on random data
        bright = 8'd0;
        for (int c = 0; c < CH; c++)
            for (int l = 0; l < LEDS; l++) ram_write(c, l, 24'($urandom));
        update_request = 1'b1;
        run_frame("bright0", 0, -1, 0, 0, 0, 0);
        bright = 8'($urandom_range(1, 254));
        update_request = 1'b1;
        run_frame("rand_bright", 0, -1, 0, 0, 0, 0);

        // Mid-frame writes: LED1 lands this frame, LED0 only next frame
        bright = 8'd255;
        update_request = 1'b1;
        run_frame("wr_led1", 0, 30, 2, 1, 24'($urandom), 0);
        @(negedge clk100);
        update_request = 1'b1;
        run_frame("wr_led0", 0, 30, 1, 0, 24'($urandom), 0);
        @(negedge clk100);
        update_request = 1'b1;
        run_frame("wr_led0_next", 0, -1, 0, 0, 0, 0);

        // Three requests while busy collapse into exactly one further frame
        @(negedge clk100);
        update_request = 1'b1;
        run_frame("pend_first", 0, -1, 0, 0, 0, 1);
        run_frame("pend_second", 0, -1, 0, 0, 0, 0);
        expect_idle("idle_after_pending", 50);

        // Auto-repeat
        refresh_en = 1'b1;
        run_frame("refresh_1", 1, -1, 0, 0, 0, 0);
        run_frame("refresh_2", 0, -1, 0, 0, 0, 0);
        expect_idle("idle_after_refresh", 20);

        // Asynchronous reset mid-bit with a pending request
        update_request = 1'b1;
        snapshot();
        @(negedge clk100);
        update_request = 1'b0;
        for (int i = 0; i <= 77; i++) begin
            @(negedge clk100);
            update_request = (i == 40);
        end
        update_request = 1'b0;
        check("midbit_dout_before_reset", 32'(DOUT),
              32'({exp_level(2, 77), exp_level(1, 77), exp_level(0, 77)}));
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({busy, RST, update_done, DOUT}), 32'd0);
        repeat (3) @(negedge clk100);
        reset_n = 1'b1;
        expect_idle("no_frame_after_reset", 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
